dataram_arbiter: RTL and testbench
==================================

Name: dataram_arbiter

Overview:
- Two-port arbiter sharing the single-port DataRAM (256 x 8, combinational read, write on CLK rising edge).
- Port 0 is the core load/store unit; port 1 is the loader/debug DMA port.
- Round-robin arbitration, request/acknowledge handshake per port, registered read data, and a bounded lock for atomic read-modify-write sequences.

Parameters:
ADDR_W, 8, address width; drives MemAddr and the per-port address inputs.
DATA_W, 8, data width.
MAX_LOCK, 4, maximum consecutive locked transactions one port may hold before the lock is ignored.

Ports:
CLK  input  1  system clock; all state updates on the rising edge
Reset  input  1  synchronous, active-high reset
Req0, Req1  input  1 each  transaction request; held until the matching Ack
We0, We1  input  1 each  1 = write, 0 = read; stable while Req is high
Lock0, Lock1  input  1 each  keep ownership for this port's next transaction
Addr0, Addr1  input  ADDR_W each  RAM address
WData0, WData1  input  DATA_W each  write data
Ack0, Ack1  output  1 each  one-cycle completion pulse
RdData  output  DATA_W  read result; valid in the Ack cycle
MemAddr  output  ADDR_W  to DataRAM Address
MemWrite  output  1  to DataRAM MemWrite
MemWriteData  output  DATA_W  to DataRAM WriteData
MemOut  input  DATA_W  from DataRAM MemOut

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset values:
  - state = IDLE, last_grant = 1 (port 0 wins the first tie), lock_owner invalid, lock_cnt = 0.
  - Ack0 = Ack1 = 0, RdData = 0, MemAddr = 0, MemWrite = 0, MemWriteData = 0.
  - Reset is synchronous but also gates MemWrite combinationally (MemWrite = 0 whenever Reset = 1), so no RAM write occurs on the reset edge, even if reset arrives in ACCESS.
- IDLE:
  - Winner selection, in priority order:
    - If lock_owner is valid and that port requests, it wins.
    - Else, if both ports request, the port != last_grant wins.
    - Else, the single requester wins.
  - A locked owner that is not requesting does not block the other port; the lock is released and lock_cnt cleared.
  - On a grant: latch winner, We, Addr, WData into internal registers; last_grant <= winner; go to ACCESS.
  - No request: stay in IDLE.
- ACCESS (exactly one cycle):
  - MemAddr = latched Addr; MemWriteData = latched WData; MemWrite = latched We.
  - At the edge: for a read, RdData <= MemOut; for a write, RdData holds its value.
  - Sample Lock[winner]:
    - If 1 and lock_cnt < MAX_LOCK-1: lock_owner <= winner, lock_cnt++.
    - Otherwise: clear lock_owner and lock_cnt = 0.
  - Go to RESP.
- RESP:
  - Ack[winner] = 1 for exactly this cycle; RdData holds the read value.
  - Requests are ignored in this cycle. The requester must drop Req, or present a new transaction, on the cycle after Ack.
  - Go to IDLE.
- Outside ACCESS: MemWrite = 0; MemAddr and MemWriteData hold the last values.
- Timing:
  - Latency from Req high (IDLE) to Ack = 2 cycles.
  - Throughput: one transaction per 3 cycles.
- Fairness:
  - Without lock, a continuously requesting port waits at most one transaction.
  - With lock, it waits at most MAX_LOCK transactions.
- Ack0 and Ack1 are never high in the same cycle.
- Address wrap-around: none; the full 8-bit range 0..255 is passed through unchanged.
- Requests that change mid-transaction are not re-sampled; the latched values are used.

Test Plan:
- Reset, then Req0 = 1, We0 = 1, Addr0 = 8'h10, WData0 = 8'hA5 -> MemWrite = 1 only in cycle 1, Ack0 in cycle 2. A following read of 8'h10 on port 0 -> RdData = 8'hA5 with Ack0.
- Req0 and Req1 both continuously high with reads at 8'h01 and 8'h02 after reset -> grants alternate 0, 1, 0, 1. The Ack pattern is Ack0 at cycle 2, Ack1 at cycle 5, Ack0 at cycle 8, and so on.
- Port 1 asserts Lock1 = 1 on 6 back-to-back transactions while Req0 stays high -> port 1 is served 4 times (MAX_LOCK), then port 0 is granted.
- Lock0 = 1 on a read of 8'h20, then port 0 drops Req while Req1 is high -> port 1 is granted at the next IDLE, and the lock is released.
- Reset asserted during ACCESS of a write of 8'h55 to 8'h30 -> MemWrite stays 0, no Ack is issued, state = IDLE, and a subsequent read of 8'h30 returns the prior contents.
- Read of 8'hFF, then a write to 8'h00 -> MemAddr = 8'hFF, then 8'h00, with no wrap artefacts; RdData holds the 8'hFF read value through the write's Ack.

Source files
------------

// File: rtl/dataram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port DataRAM.
// master: requester/RAM side (drives requests and MemOut, receives acks and RAM controls).
// slave : arbiter side (receives requests and MemOut, drives acks, RdData and RAM controls).
interface dataram_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              Req0;
  logic              Req1;
  logic              We0;
  logic              We1;
  logic              Lock0;
  logic              Lock1;
  logic [ADDR_W-1:0] Addr0;
  logic [ADDR_W-1:0] Addr1;
  logic [DATA_W-1:0] WData0;
  logic [DATA_W-1:0] WData1;
  logic              Ack0;
  logic              Ack1;
  logic [DATA_W-1:0] RdData;
  logic [ADDR_W-1:0] MemAddr;
  logic              MemWrite;
  logic [DATA_W-1:0] MemWriteData;
  logic [DATA_W-1:0] MemOut;

  modport master (
    output Req0, Req1, We0, We1, Lock0, Lock1, Addr0, Addr1, WData0, WData1, MemOut,
    input  Ack0, Ack1, RdData, MemAddr, MemWrite, MemWriteData
  );

  modport slave (
    input  Req0, Req1, We0, We1, Lock0, Lock1, Addr0, Addr1, WData0, WData1, MemOut,
    output Ack0, Ack1, RdData, MemAddr, MemWrite, MemWriteData
  );
endinterface

// File: rtl/dataram_arbiter.sv
// Round-robin two-port arbiter in front of the single-port DataRAM.
// Port 0 = core load/store unit, port 1 = loader/debug DMA.
// Ports: CLK, Reset (sync, active-high), bus (slave modport: per-port Req/We/Lock/Addr/WData
// in, Ack/RdData out, plus MemAddr/MemWrite/MemWriteData to the RAM and MemOut from it).
// One transaction takes IDLE -> ACCESS -> RESP; Ack pulses in RESP. A port may hold the RAM
// for up to MAX_LOCK consecutive transactions via its Lock input.
module dataram_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic                 CLK,
  input  logic                 Reset,
  dataram_arbiter_if.slave     bus
);

  localparam int unsigned CNT_W = (MAX_LOCK < 2) ? 1 : $clog2(MAX_LOCK);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e              state_q,      state_d;
  logic                last_grant_q, last_grant_d;
  logic                lock_valid_q, lock_valid_d;
  logic                lock_owner_q, lock_owner_d;
  logic [CNT_W-1:0]    lock_cnt_q,   lock_cnt_d;
  logic                winner_q,     winner_d;
  logic                we_q,         we_d;
  logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q,  mem_wdata_d;
  logic [DATA_W-1:0]   rd_data_q,    rd_data_d;
  logic [1:0]          ack_q,        ack_d;

  logic [1:0]          req;
  logic [1:0]          lock_in;
  logic                grant;
  logic                win;
  logic                mem_write_c;

  assign req     = {bus.Req1,  bus.Req0};
  assign lock_in = {bus.Lock1, bus.Lock0};

  // State register and all registered outputs.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      lock_valid_q <= 1'b0;
      lock_owner_q <= 1'b0;
      lock_cnt_q   <= '0;
      winner_q     <= 1'b0;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rd_data_q    <= '0;
      ack_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      winner_q     <= winner_d;
      we_q         <= we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_data_q    <= rd_data_d;
      ack_q        <= ack_d;
    end
  end

  // Next-state, arbitration and lock bookkeeping.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = lock_cnt_q;
    winner_d     = winner_q;
    we_d         = we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rd_data_d    = rd_data_q;
    ack_d        = '0;
    grant        = 1'b0;
    win          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // An idle lock owner must not starve the other port.
        if (lock_valid_q && !req[lock_owner_q]) begin
          lock_valid_d = 1'b0;
          lock_cnt_d   = '0;
        end

        if (lock_valid_q && req[lock_owner_q]) begin
          grant = 1'b1;
          win   = lock_owner_q;
        end else if (req[0] && req[1]) begin
          grant = 1'b1;
          win   = ~last_grant_q;
        end else if (req[0]) begin
          grant = 1'b1;
          win   = 1'b0;
        end else if (req[1]) begin
          grant = 1'b1;
          win   = 1'b1;
        end

        if (grant) begin
          winner_d     = win;
          we_d         = win ? bus.We1    : bus.We0;
          mem_addr_d   = win ? bus.Addr1  : bus.Addr0;
          mem_wdata_d  = win ? bus.WData1 : bus.WData0;
          last_grant_d = win;
          state_d      = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (!we_q) begin
          rd_data_d = bus.MemOut;
        end
        // Lock extends ownership only while under the consecutive-transaction limit.
        if (lock_in[winner_q] && (lock_cnt_q < CNT_W'(MAX_LOCK - 1))) begin
          lock_valid_d = 1'b1;
          lock_owner_d = winner_q;
          lock_cnt_d   = lock_cnt_q + CNT_W'(1);
        end else begin
          lock_valid_d = 1'b0;
          lock_cnt_d   = '0;
        end
        ack_d[winner_q] = 1'b1;
        state_d         = S_RESP;
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Write strobe is combinational so Reset can suppress a write on the reset edge.
  assign mem_write_c = (state_q == S_ACCESS) && we_q && !Reset;

  assign bus.MemWrite     = mem_write_c;
  assign bus.MemAddr      = mem_addr_q;
  assign bus.MemWriteData = mem_wdata_q;
  assign bus.RdData       = rd_data_q;
  assign bus.Ack0         = ack_q[0];
  assign bus.Ack1         = ack_q[1];

endmodule

// File: tb/tb_dataram_arbiter.sv
// Directed bench for dataram_arbiter with a behavioural 256x8 DataRAM.
module tb_dataram_arbiter;

  logic CLK;
  logic Reset;
  int   n_checks;
  int   n_errors;
  logic [7:0] mem [256];

  dataram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  dataram_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_LOCK(4)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM: combinational read, write on rising edge.
  assign bus.MemOut = mem[bus.MemAddr];
  always @(posedge CLK) begin
    if (bus.MemWrite) mem[bus.MemAddr] <= bus.MemWriteData;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int p, input logic req, input logic we, input logic lock,
                       input logic [7:0] addr, input logic [7:0] wd);
    if (p == 0) begin
      bus.Req0 = req; bus.We0 = we; bus.Lock0 = lock; bus.Addr0 = addr; bus.WData0 = wd;
    end else begin
      bus.Req1 = req; bus.We1 = we; bus.Lock1 = lock; bus.Addr1 = addr; bus.WData1 = wd;
    end
  endtask

  task automatic do_reset();
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
  endtask

  // One isolated transaction starting in IDLE; exp_rd is RdData expected in the Ack cycle.
  task automatic run_single(input int p, input logic we, input logic [7:0] addr,
                            input logic [7:0] wd, input logic [7:0] exp_rd);
    drive(p, 1'b1, we, 1'b0, addr, wd);
    step();
    check("acc_memwrite", 32'(bus.MemWrite), 32'(we));
    check("acc_memaddr", 32'(bus.MemAddr), 32'(addr));
    if (we) check("acc_wdata", 32'(bus.MemWriteData), 32'(wd));
    check("acc_noack", 32'({bus.Ack1, bus.Ack0}), 32'd0);
    step();
    check("resp_ack", 32'({bus.Ack1, bus.Ack0}), (p == 0) ? 32'd1 : 32'd2);
    check("resp_memwrite", 32'(bus.MemWrite), 32'd0);
    check("resp_rddata", 32'(bus.RdData), 32'(exp_rd));
    drive(p, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    check("idle_noack", 32'({bus.Ack1, bus.Ack0}), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    Reset    = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h01] = 8'h11;
    mem[8'h02] = 8'h22;
    mem[8'h03] = 8'h33;
    mem[8'h04] = 8'h44;
    mem[8'h20] = 8'h5C;
    mem[8'h21] = 8'h66;
    mem[8'hFF] = 8'hC3;

    // Reset values
    do_reset();
    check("rst_ack", 32'({bus.Ack1, bus.Ack0}), 32'd0);
    check("rst_rddata", 32'(bus.RdData), 32'd0);
    check("rst_memaddr", 32'(bus.MemAddr), 32'd0);
    check("rst_memwrite", 32'(bus.MemWrite), 32'd0);
    check("rst_memwdata", 32'(bus.MemWriteData), 32'd0);

    // Write then read back on port 0
    run_single(0, 1'b1, 8'h10, 8'hA5, 8'h00);
    check("ram_10", 32'(mem[8'h10]), 32'hA5);
    run_single(0, 1'b0, 8'h10, 8'h00, 8'hA5);

    // Top address then bottom address; RdData holds across the write
    run_single(1, 1'b0, 8'hFF, 8'h00, 8'hC3);
    run_single(1, 1'b1, 8'h00, 8'h5A, 8'hC3);
    check("ram_00", 32'(mem[8'h00]), 32'h5A);

    // Reset arriving in ACCESS of a write must not write the RAM
    run_single(0, 1'b1, 8'h30, 8'h77, 8'hC3);
    drive(0, 1'b1, 1'b1, 1'b0, 8'h30, 8'h55);
    step();
    check("abort_pre_memwrite", 32'(bus.MemWrite), 32'd1);
    Reset = 1'b1;
    #1;
    check("abort_memwrite_gated", 32'(bus.MemWrite), 32'd0);
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    check("abort_ack", 32'({bus.Ack1, bus.Ack0}), 32'd0);
    check("abort_rddata", 32'(bus.RdData), 32'd0);
    check("abort_memaddr", 32'(bus.MemAddr), 32'd0);
    Reset = 1'b0;
    step();
    check("abort_idle_ack", 32'({bus.Ack1, bus.Ack0}), 32'd0);
    check("abort_ram_30", 32'(mem[8'h30]), 32'h77);
    run_single(0, 1'b0, 8'h30, 8'h00, 8'h77);

    // Round-robin with both ports continuously requesting
    do_reset();
    drive(0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
    drive(1, 1'b1, 1'b0, 1'b0, 8'h02, 8'h00);
    for (int c = 1; c <= 12; c++) begin
      step();
      check($sformatf("rr_ack0_c%0d", c), 32'(bus.Ack0), (c == 2 || c == 8) ? 32'd1 : 32'd0);
      check($sformatf("rr_ack1_c%0d", c), 32'(bus.Ack1), (c == 5 || c == 11) ? 32'd1 : 32'd0);
      if (c == 2 || c == 8) check($sformatf("rr_rd_c%0d", c), 32'(bus.RdData), 32'h11);
      if (c == 5 || c == 11) check($sformatf("rr_rd_c%0d", c), 32'(bus.RdData), 32'h22);
    end

    // Port 1 locks; port 0 waits MAX_LOCK transactions
    do_reset();
    drive(1, 1'b1, 1'b0, 1'b1, 8'h03, 8'h00);
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 1) drive(0, 1'b1, 1'b0, 1'b0, 8'h04, 8'h00);
      check($sformatf("lk_ack1_c%0d", c), 32'(bus.Ack1),
            (c == 2 || c == 5 || c == 8 || c == 11) ? 32'd1 : 32'd0);
      check($sformatf("lk_ack0_c%0d", c), 32'(bus.Ack0), (c == 14) ? 32'd1 : 32'd0);
    end
    check("lk_rd_port0", 32'(bus.RdData), 32'h44);

    // Lock owner drops Req: other port is granted at the next IDLE
    do_reset();
    drive(0, 1'b1, 1'b0, 1'b1, 8'h20, 8'h00);
    for (int c = 1; c <= 5; c++) begin
      step();
      check($sformatf("rel_ack0_c%0d", c), 32'(bus.Ack0), (c == 2) ? 32'd1 : 32'd0);
      check($sformatf("rel_ack1_c%0d", c), 32'(bus.Ack1), (c == 5) ? 32'd1 : 32'd0);
      if (c == 2) begin
        check("rel_rd_20", 32'(bus.RdData), 32'h5C);
        drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b1, 1'b0, 1'b0, 8'h21, 8'h00);
      end
    end
    check("rel_rd_21", 32'(bus.RdData), 32'h66);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
